// File: rtl/tdc_meas_ctrl.sv
// Per-channel TDC measurement sequencer: opens a coarse-count window on trig, issues a
// fixed-length calculator enable burst per hit (start + up to MAX_STOP stops) and queues
// the calculator results in a small FIFO for a valid/ready consumer.
module tdc_meas_ctrl #(
  parameter int unsigned CAL_LEN   = 5,
  parameter int unsigned MAX_STOP  = 3,
  parameter int unsigned RES_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig,
  input  logic [14:0] range,
  input  logic        hit,
  output logic        cal_en,
  output logic [2:0]  cnt,
  output logic [9:0]  counter_out,
  output logic [1:0]  num_cnt,
  output logic        tri_en,
  input  logic        cal_valid,
  input  logic [14:0] cal_data,
  output logic [14:0] res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        ovf
);

  localparam int unsigned CalW = (CAL_LEN > 1) ? $clog2(CAL_LEN) : 1;
  localparam int unsigned PtrW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam logic [1:0]      MaxStop = 2'(MAX_STOP);
  localparam logic [CalW-1:0] CalLast = CalW'(CAL_LEN - 1);
  localparam logic [CalW-1:0] CalOne  = CalW'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [PtrW:0]   CntOne  = (PtrW + 1)'(1);
  localparam logic [PtrW:0]   Depth   = (PtrW + 1)'(RES_DEPTH);

  typedef enum logic [2:0] {StIdle, StArmed, StRun, StCal, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [9:0]      counter_q, counter_d;
  logic [9:0]      win_q, win_d;
  logic [9:0]      tmo_q, tmo_d;
  logic [1:0]      num_q, num_d;
  logic [CalW-1:0] cal_cnt_q, cal_cnt_d;
  logic            pend_q, pend_d;
  logic            ovf_q, ovf_d;

  logic [14:0]     mem_q [RES_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;

  logic win_open, stop_ok, push, push_ok, pop, fifo_full;
  logic unused_range_lsb;

  // Only the coarse part of range sets the window.
  assign unused_range_lsb = ^range[4:0];

  assign win_open  = (counter_q != win_q);
  assign stop_ok   = win_open && (num_q < MaxStop);
  assign res_valid = (count_q != '0);
  assign fifo_full = (count_q == Depth);
  assign pop       = res_valid && res_ready;

  // Frame sequencing: next state, counters, pending-hit slot and sticky overflow.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    counter_d = counter_q;
    win_d     = win_q;
    tmo_d     = tmo_q;
    num_d     = num_q;
    cal_cnt_d = cal_cnt_q;
    pend_d    = pend_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    tri_en    = 1'b0;

    // Coarse counter runs from the start hit and freezes once the window closes.
    if ((state_q inside {StRun, StCal, StWait}) && win_open) begin
      counter_d = counter_q + 10'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (trig && !rst) begin
          state_d   = StArmed;
          tri_en    = 1'b1;
          num_d     = '0;
          counter_d = '0;
          ovf_d     = 1'b0;
          pend_d    = 1'b0;
          tmo_d     = '0;
          win_d     = range[14:5];
        end
      end
      StArmed: begin
        if (hit) begin
          state_d   = StCal;
          cnt_d     = 3'd1;
          cal_cnt_d = '0;
        end else if (tmo_q == 10'h3ff) begin
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + 10'd1;
        end
      end
      StRun: begin
        if (!win_open) begin
          // A pending hit cannot be serviced once the window has closed.
          state_d = StDone;
          pend_d  = 1'b0;
        end else if (stop_ok && (pend_q || hit)) begin
          state_d   = StCal;
          cnt_d     = {1'b0, num_q} + 3'd2;
          num_d     = num_q + 2'd1;
          cal_cnt_d = '0;
          // Serving the pending slot while a fresh hit arrives: the fresh hit re-fills it.
          pend_d    = pend_q && hit && ((num_q + 2'd1) < MaxStop);
        end
      end
      StCal: begin
        if (hit && stop_ok) begin
          if (pend_q) ovf_d = 1'b1;
          else        pend_d = 1'b1;
        end
        if (cal_cnt_q == CalLast) begin
          state_d = StWait;
        end else begin
          cal_cnt_d = cal_cnt_q + CalOne;
        end
      end
      StWait: begin
        if (hit && stop_ok) begin
          if (pend_q) ovf_d = 1'b1;
          else        pend_d = 1'b1;
        end
        if (cal_valid) begin
          push = 1'b1;
          if (fifo_full && !pop) ovf_d = 1'b1;
          if (!win_open || ((num_q == MaxStop) && !pend_q)) state_d = StDone;
          else                                               state_d = StRun;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Result FIFO bookkeeping; a pop in the same cycle frees room for a push into a full FIFO.
  always_comb begin
    push_ok  = push && (!fifo_full || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + CntOne;
    else if (!push_ok && pop) count_d = count_q - CntOne;
  end

  // State registers with synchronous reset; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      counter_q <= '0;
      win_q     <= '0;
      tmo_q     <= '0;
      num_q     <= '0;
      cal_cnt_q <= '0;
      pend_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      counter_q <= counter_d;
      win_q     <= win_d;
      tmo_q     <= tmo_d;
      num_q     <= num_d;
      cal_cnt_q <= cal_cnt_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage; contents are only observable through res_valid, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= cal_data;
  end

  assign cal_en      = (state_q == StCal);
  assign busy        = (state_q != StIdle);
  assign frame_done  = (state_q == StDone);
  assign cnt         = cnt_q;
  assign counter_out = counter_q;
  assign num_cnt     = num_q;
  assign ovf         = ovf_q;
  assign res_data    = res_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Self-checking bench for tdc_meas_ctrl: a calculator model answers each cal_en burst,
// every result it returns is queued as an expected FIFO entry and checked when drained.
module tb_tdc_meas_ctrl;

  localparam int CalLen   = 5;
  localparam int ResDepth = 4;
  localparam int RetDly   = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig = 1'b0;
  logic [14:0] range = '0;
  logic        hit = 1'b0;
  logic        cal_valid = 1'b0;
  logic [14:0] cal_data = '0;
  logic        res_ready = 1'b0;
  logic        cal_en, tri_en, res_valid, busy, frame_done, ovf;
  logic [2:0]  cnt;
  logic [9:0]  counter_out;
  logic [1:0]  num_cnt;
  logic [14:0] res_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [14:0] exp_q[$];
  int          burst_cnt_q[$];
  int          burst_len_q[$];
  logic [14:0] exp_d;
  logic [2:0]  bcnt;
  int  blen = 0, calc_cd = 0, cyc = 0, cnt_unstable = 0, cal_cycles = 0, n_pops = 0;
  int  done_cnt = 0, done_counter = 0, done_num = 0, done_cyc = 0, last_valid_cyc = 0;
  bit  in_burst = 1'b0;

  tdc_meas_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .trig        (trig),
    .range       (range),
    .hit         (hit),
    .cal_en      (cal_en),
    .cnt         (cnt),
    .counter_out (counter_out),
    .num_cnt     (num_cnt),
    .tri_en      (tri_en),
    .cal_valid   (cal_valid),
    .cal_data    (cal_data),
    .res_data    (res_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  // Calculator model, burst monitor and scoreboard, all on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      calc_cd   = 0;
      cal_valid = 1'b0;
      in_burst  = 1'b0;
      blen      = 0;
    end else begin
      if (res_valid && res_ready) begin
        n_checks++;
        n_pops++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_pop: popped res_data=%h, expected no entry", res_data);
        end else begin
          exp_d = exp_q.pop_front();
          if (res_data !== exp_d) begin
            n_fail++;
            $display("FAIL scoreboard_data: res_data=%h expected %h", res_data, exp_d);
          end
        end
      end
      cal_valid = 1'b0;
      if (calc_cd != 0) begin
        calc_cd--;
        if (calc_cd == 0) begin
          cal_valid      = 1'b1;
          cal_data       = 15'($urandom());
          last_valid_cyc = cyc;
          // Model FIFO: any pop at this edge was taken above, so a full FIFO may still accept.
          if (exp_q.size() < ResDepth) exp_q.push_back(cal_data);
        end
      end
      if (cal_en) begin
        if (!in_burst) bcnt = cnt;
        else if (cnt !== bcnt) cnt_unstable++;
        in_burst = 1'b1;
        blen++;
        cal_cycles++;
      end else if (in_burst) begin
        burst_cnt_q.push_back(int'(bcnt));
        burst_len_q.push_back(blen);
        in_burst = 1'b0;
        blen     = 0;
        calc_cd  = RetDly;
      end
      if (frame_done) begin
        done_cnt++;
        done_counter = int'(counter_out);
        done_num     = int'(num_cnt);
        done_cyc     = cyc;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    step();
    hit = 1'b0;
  endtask

  task automatic start_frame(input logic [9:0] win);
    range = {win, 5'd0};
    trig  = 1'b1;
    step();
    trig  = 1'b0;
  endtask

  task automatic wait_counter(input int c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (int'(counter_out) == c) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && !res_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    res_ready = 1'b0;
  endtask

  task automatic clear_obs();
    burst_cnt_q.delete();
    burst_len_q.delete();
    cnt_unstable = 0;
    done_cnt     = 0;
    n_pops       = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    n_checks++;
    if ({cal_en, tri_en, busy, frame_done, ovf, res_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000000",
               {cal_en, tri_en, busy, frame_done, ovf, res_valid});
    end
    n_checks++;
    if ({cnt, counter_out, num_cnt, res_data} !== 30'b0) begin
      n_fail++;
      $display("FAIL reset_values: cnt=%0d counter=%0d num=%0d data=%h expected all 0",
               cnt, counter_out, num_cnt, res_data);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    bit ok;
    clear_obs();
    res_ready = 1'b0;
    range = {10'd96, 5'd0};
    trig  = 1'b1;
    #1;
    n_checks++;
    if (tri_en !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_tri_en: got %b expected 1", tri_en);
    end
    step();
    trig = 1'b0;
    #1;
    n_checks++;
    if ({tri_en, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL basic_armed: tri_en,busy=%b expected 01", {tri_en, busy});
    end
    step(2);
    pulse_hit();
    wait_counter(20, ok);
    pulse_hit();
    if (ok) wait_counter(50, ok);
    pulse_hit();
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_counter_reach: counter=%0d never hit 20/50", counter_out);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok || done_cnt != 1 || done_counter != 96) begin
      n_fail++;
      $display("FAIL basic_done: done_pulses=%0d at counter %0d, expected 1 at 96",
               done_cnt, done_counter);
    end
    n_checks++;
    if (done_num != 2 || int'(num_cnt) != 2 || int'(counter_out) != 96) begin
      n_fail++;
      $display("FAIL basic_hold: num=%0d/%0d counter=%0d expected 2/2 96",
               done_num, num_cnt, counter_out);
    end
    n_checks++;
    if (burst_cnt_q.size() != 3 || cnt_unstable != 0) begin
      n_fail++;
      $display("FAIL basic_bursts: count=%0d unstable=%0d expected 3 0",
               burst_cnt_q.size(), cnt_unstable);
    end
    for (int i = 0; i < burst_cnt_q.size(); i++) begin
      n_checks++;
      if (burst_cnt_q[i] != i + 1 || burst_len_q[i] != CalLen) begin
        n_fail++;
        $display("FAIL basic_burst%0d: cnt=%0d len=%0d expected %0d %0d",
                 i, burst_cnt_q[i], burst_len_q[i], i + 1, CalLen);
      end
    end
    n_checks++;
    if (exp_q.size() != 3 || res_valid !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_fifo: queued=%0d res_valid=%b ovf=%b expected 3 1 0",
               exp_q.size(), res_valid, ovf);
    end
    drain(ok);
    n_checks++;
    if (!ok || n_pops != 3) begin
      n_fail++;
      $display("FAIL basic_drain: pops=%0d expected 3", n_pops);
    end
  endtask

  task automatic test_max_stops();
    bit ok;
    clear_obs();
    start_frame(10'd1000);
    n_checks++;
    if (num_cnt !== 2'd0 || counter_out !== 10'd0) begin
      n_fail++;
      $display("FAIL max_trig_clear: num=%0d counter=%0d expected 0 0", num_cnt, counter_out);
    end
    step(2);
    pulse_hit();
    wait_counter(20, ok);
    for (int k = 0; k < 5; k++) begin
      pulse_hit();
      step(9);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok || done_num != 3 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL max_num: num=%0d ovf=%b expected 3 0", done_num, ovf);
    end
    n_checks++;
    if (done_cnt != 1 || done_cyc != last_valid_cyc + 1) begin
      n_fail++;
      $display("FAIL max_done_time: done at cycle %0d, expected %0d",
               done_cyc, last_valid_cyc + 1);
    end
    n_checks++;
    if (burst_cnt_q.size() != 4) begin
      n_fail++;
      $display("FAIL max_bursts: count=%0d expected 4", burst_cnt_q.size());
    end
    for (int i = 0; i < burst_cnt_q.size(); i++) begin
      n_checks++;
      if (burst_cnt_q[i] != i + 1 || burst_len_q[i] != CalLen) begin
        n_fail++;
        $display("FAIL max_burst%0d: cnt=%0d len=%0d expected %0d %0d",
                 i, burst_cnt_q[i], burst_len_q[i], i + 1, CalLen);
      end
    end
    drain(ok);
    n_checks++;
    if (!ok || n_pops != 4) begin
      n_fail++;
      $display("FAIL max_drain: pops=%0d expected 4", n_pops);
    end
  endtask

  task automatic test_hit_during_cal();
    bit ok;
    clear_obs();
    start_frame(10'd64);
    step(2);
    pulse_hit();
    wait_counter(20, ok);
    pulse_hit();
    step(1);
    pulse_hit();
    step(1);
    pulse_hit();
    trig = 1'b1;
    #1;
    n_checks++;
    if (tri_en !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_trig_ignored: tri_en=%b expected 0", tri_en);
    end
    step();
    trig = 1'b0;
    n_checks++;
    if (ovf !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_ovf: ovf=%b busy=%b expected 1 1", ovf, busy);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok || done_num != 2 || done_counter != 64 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_done: num=%0d counter=%0d ovf=%b expected 2 64 1",
               done_num, done_counter, ovf);
    end
    n_checks++;
    if (burst_cnt_q.size() != 3) begin
      n_fail++;
      $display("FAIL pend_bursts: count=%0d expected 3", burst_cnt_q.size());
    end
    for (int i = 0; i < burst_cnt_q.size(); i++) begin
      n_checks++;
      if (burst_cnt_q[i] != i + 1) begin
        n_fail++;
        $display("FAIL pend_burst%0d: cnt=%0d expected %0d", i, burst_cnt_q[i], i + 1);
      end
    end
    drain(ok);
    n_checks++;
    if (!ok || n_pops != 3) begin
      n_fail++;
      $display("FAIL pend_drain: pops=%0d expected 3", n_pops);
    end
  endtask

  task automatic test_fifo_full();
    bit ok;
    clear_obs();
    res_ready = 1'b0;
    start_frame(10'd1000);
    step(2);
    pulse_hit();
    wait_counter(20, ok);
    pulse_hit();
    wait_counter(40, ok);
    pulse_hit();
    wait_counter(60, ok);
    pulse_hit();
    wait_idle(ok);
    n_checks++;
    if (!ok || exp_q.size() != 4 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL full_first: queued=%0d ovf=%b expected 4 0", exp_q.size(), ovf);
    end
    // Zero-length window: only the start hit is measured.
    start_frame(10'd0);
    step(2);
    pulse_hit();
    wait_idle(ok);
    n_checks++;
    if (!ok || ovf !== 1'b1 || done_counter != 0 || done_cnt != 2) begin
      n_fail++;
      $display("FAIL full_ovf: ovf=%b counter=%0d frames=%0d expected 1 0 2",
               ovf, done_counter, done_cnt);
    end
    n_checks++;
    if (burst_cnt_q.size() != 5 || burst_cnt_q[burst_cnt_q.size() - 1] != 1) begin
      n_fail++;
      $display("FAIL full_bursts: count=%0d expected 5 ending with cnt 1", burst_cnt_q.size());
    end
    drain(ok);
    n_checks++;
    if (!ok || n_pops != 4 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL full_drain: pops=%0d ovf=%b expected 4 1", n_pops, ovf);
    end
  endtask

  task automatic test_timeout();
    bit found;
    int cycles;
    int cal0;
    bit ok;
    clear_obs();
    cal0 = cal_cycles;
    start_frame(10'd100);
    found  = 1'b0;
    cycles = 0;
    for (int i = 0; i < 1100; i++) begin
      if (frame_done) begin
        found = 1'b1;
        break;
      end
      step();
      cycles++;
    end
    n_checks++;
    if (!found || cycles != 1024) begin
      n_fail++;
      $display("FAIL timeout_len: frame_done after %0d cycles (seen=%b) expected 1024",
               cycles, found);
    end
    n_checks++;
    if (cal_cycles != cal0 || num_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL timeout_no_cal: cal_en cycles=%0d num=%0d expected 0 0",
               cal_cycles - cal0, num_cnt);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok || done_cnt != 1) begin
      n_fail++;
      $display("FAIL timeout_idle: frames=%0d busy=%b expected 1 0", done_cnt, busy);
    end
  endtask

  task automatic test_window_boundary();
    bit ok;
    clear_obs();
    start_frame(10'd30);
    step(2);
    pulse_hit();
    wait_counter(30, ok);
    pulse_hit();
    wait_idle(ok);
    n_checks++;
    if (!ok || burst_cnt_q.size() != 1 || done_num != 0 || done_counter != 30) begin
      n_fail++;
      $display("FAIL win_close_hit: bursts=%0d num=%0d counter=%0d expected 1 0 30",
               burst_cnt_q.size(), done_num, done_counter);
    end
    start_frame(10'd30);
    step(2);
    pulse_hit();
    wait_counter(29, ok);
    pulse_hit();
    wait_idle(ok);
    n_checks++;
    if (!ok || burst_cnt_q.size() != 3 || done_num != 1 || done_counter != 30) begin
      n_fail++;
      $display("FAIL win_last_open: bursts=%0d num=%0d counter=%0d expected 3 1 30",
               burst_cnt_q.size(), done_num, done_counter);
    end
    drain(ok);
    n_checks++;
    if (!ok || n_pops != 3) begin
      n_fail++;
      $display("FAIL win_drain: pops=%0d expected 3", n_pops);
    end
  endtask

  task automatic test_reset_mid_cal();
    bit ok;
    int d0;
    clear_obs();
    res_ready = 1'b0;
    start_frame(10'd100);
    step(2);
    pulse_hit();
    wait_counter(20, ok);
    pulse_hit();
    step(2);
    n_checks++;
    if (cal_en !== 1'b1 || res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstcal_pre: cal_en=%b res_valid=%b expected 1 1", cal_en, res_valid);
    end
    d0  = done_cnt;
    rst = 1'b1;
    step();
    n_checks++;
    if ({cal_en, res_valid, busy, frame_done} !== 4'b0) begin
      n_fail++;
      $display("FAIL rstcal_post: cal_en,res_valid,busy,frame_done=%b expected 0000",
               {cal_en, res_valid, busy, frame_done});
    end
    n_checks++;
    if (num_cnt !== 2'd0 || counter_out !== 10'd0) begin
      n_fail++;
      $display("FAIL rstcal_regs: num=%0d counter=%0d expected 0 0", num_cnt, counter_out);
    end
    rst = 1'b0;
    step(20);
    n_checks++;
    if (done_cnt != d0 || busy !== 1'b0 || cal_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rstcal_quiet: frame_done pulses=%0d busy=%b expected 0 0",
               done_cnt - d0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_stops();
    test_hit_during_cal();
    test_fifo_full();
    test_timeout();
    test_window_boundary();
    test_reset_mid_cal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
